// File: rtl/fp_pkg.sv
// Shared types and constants for the FP operand-fetch slice.
package fp_pkg;

    localparam int NREG  = 32;
    localparam int FLEN  = 32;
    localparam int IDX_W = $clog2(NREG);

    typedef logic [IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        FSGNJ  = 2'd0,
        FSGNJN = 2'd1,
        FSGNJX = 2'd2,
        RSVD   = 2'd3
    } fp_op_e;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/fp_regfile.sv
// 32x32 FP register file: two asynchronous read ports with write-through
// bypass, one synchronous write port, all entries cleared on reset.
module fp_regfile
    import fp_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  reg_idx_t        raddr1,
    input  reg_idx_t        raddr2,
    output logic [FLEN-1:0] rdata1,
    output logic [FLEN-1:0] rdata2,
    input  logic            we,
    input  reg_idx_t        waddr,
    input  logic [FLEN-1:0] wdata
);

    logic [FLEN-1:0] mem [NREG];

    // Storage array; reset returns every entry to +0.0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports see a same-cycle write so a dependent issue needs no extra cycle.
    always_comb begin
        rdata1 = (we && (waddr == raddr1)) ? wdata : mem[raddr1];
        rdata2 = (we && (waddr == raddr2)) ? wdata : mem[raddr2];
    end

endmodule

// File: rtl/fp_operand_fetch.sv
// Issue / operand-fetch stage ahead of the FP sign-injection unit.
// Holds the register file, a pending-write scoreboard, a one-entry output
// register with valid/ready handshake, and a saturating stall counter.
module fp_operand_fetch
    import fp_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      out_op,
    output logic [FLEN-1:0] out_rs1,
    output logic [FLEN-1:0] out_rs2,
    output logic [4:0]      out_rd,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [FLEN-1:0] wb_data,
    output logic [NREG-1:0] pending,
    output logic [15:0]     stall_cnt
);

    localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

    out_state_e      state_q, state_d;
    logic            vld_p1;
    fp_op_e          op_p1;
    logic [FLEN-1:0] rs1_p1, rs2_p1;
    reg_idx_t        rd_p1;

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] wb_mask, set_mask, live;
    logic            hz, accept;
    logic [15:0]     stall_q;
    logic [FLEN-1:0] rf_rdata1, rf_rdata2;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    fp_regfile u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (in_rs1),
        .raddr2 (in_rs2),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2),
        .we     (wb_valid),
        .waddr  (wb_rd),
        .wdata  (wb_data)
    );

    // Hazard detection: a register retiring this cycle no longer blocks issue.
    always_comb begin
        wb_mask  = wb_valid ? (ONE_HOT0 << wb_rd) : '0;
        live     = pend_q & ~wb_mask;
        hz       = live[in_rs1] | live[in_rs2] | live[in_rd];
        in_ready = ~hz & (~vld_p1 | out_ready);
        accept   = in_valid & in_ready;
        set_mask = accept ? (ONE_HOT0 << in_rd) : '0;
    end

    // Output-register state: EMPTY/FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: fill on accept, drain when consumed without a refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: if (accept) state_d = OUT_FULL;
            OUT_FULL:  if (out_ready && !accept) state_d = OUT_EMPTY;
            default:   state_d = OUT_EMPTY;
        endcase
    end

    assign vld_p1 = (state_q == OUT_FULL);

    // ---- stage boundary: operand bundle registered on accept, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_p1  <= FSGNJ;
            rs1_p1 <= '0;
            rs2_p1 <= '0;
            rd_p1  <= '0;
        end else if (accept) begin
            op_p1  <= fp_op_e'(in_op);
            rs1_p1 <= rf_rdata1;
            rs2_p1 <= rf_rdata2;
            rd_p1  <= in_rd;
        end
    end

    // Scoreboard: writeback clears, issue sets; set applied last so it wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~wb_mask) | set_mask;
        end
    end

    // Stall counter: cycles where an op is offered but refused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (in_valid && !in_ready) begin
            stall_q <= sat_inc(stall_q);
        end
    end

    assign out_valid = vld_p1;
    assign out_op    = op_p1;
    assign out_rs1   = rs1_p1;
    assign out_rs2   = rs2_p1;
    assign out_rd    = rd_p1;
    assign pending   = pend_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_fp_operand_fetch.sv
// Self-checking bench for fp_operand_fetch: directed scenarios plus random
// traffic, compared every cycle against a behavioural model.
module tb_fp_operand_fetch;

    logic        clk, rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, wb_valid;
    logic [1:0]  in_op, out_op;
    logic [4:0]  in_rs1, in_rs2, in_rd, out_rd, wb_rd;
    logic [31:0] out_rs1, out_rs2, wb_data, pending;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_err    = 0;

    // behavioural model state
    logic [31:0] mregs [32];
    logic [31:0] mpend;
    logic        mvalid;
    logic [1:0]  mop;
    logic [31:0] mrs1, mrs2;
    logic [4:0]  mrd;
    logic [15:0] mstall;

    fp_operand_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .pending(pending), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_busy(input logic [4:0] i);
        return mpend[i] && !(wb_valid && (wb_rd == i));
    endfunction

    function automatic logic m_ready();
        return !(m_busy(in_rs1) || m_busy(in_rs2) || m_busy(in_rd)) && (!mvalid || out_ready);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] i);
        return (wb_valid && (wb_rd == i)) ? wb_data : mregs[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        mpend = 32'h0; mvalid = 1'b0; mop = 2'd0;
        mrs1 = 32'h0; mrs2 = 32'h0; mrd = 5'd0; mstall = 16'h0;
    endtask

    task automatic model_step();
        logic rdy;
        rdy = m_ready();
        if (in_valid && !rdy && mstall != 16'hFFFF) mstall = mstall + 16'd1;
        if (in_valid && rdy) begin
            mop = in_op; mrd = in_rd; mrs1 = m_read(in_rs1); mrs2 = m_read(in_rs2);
            mvalid = 1'b1;
        end else if (out_ready) begin
            mvalid = 1'b0;
        end
        if (wb_valid) begin
            mregs[wb_rd] = wb_data;
            mpend[wb_rd] = 1'b0;
        end
        if (in_valid && rdy) mpend[in_rd] = 1'b1;
    endtask

    task automatic compare();
        chk("out_valid", {31'b0, out_valid}, {31'b0, mvalid});
        chk("out_op",    {30'b0, out_op},    {30'b0, mop});
        chk("out_rs1",   out_rs1,            mrs1);
        chk("out_rs2",   out_rs2,            mrs2);
        chk("out_rd",    {27'b0, out_rd},    {27'b0, mrd});
        chk("pending",   pending,            mpend);
        chk("stall_cnt", {16'b0, stall_cnt}, {16'b0, mstall});
    endtask

    // Inputs are driven at the negedge before calling this.
    task automatic cycle();
        #1;
        chk("in_ready", {31'b0, in_ready}, {31'b0, m_ready()});
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic set_idle();
        in_valid = 0; in_op = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        out_ready = 1; wb_valid = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd);
        in_valid = 1; in_op = op; in_rs1 = r1; in_rs2 = r2; in_rd = rd;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        wb_valid = 1; wb_rd = rd; wb_data = d;
    endtask

    // Pulse reset for one cycle; whatever is on the inputs is in flight.
    task automatic do_reset();
        rst_n = 0;
        #1;
        chk("ready_in_reset", {31'b0, in_ready}, 32'd1);
        chk("valid_in_reset", {31'b0, out_valid}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        compare();
    endtask

    initial begin
        rst_n = 0;
        set_idle();
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        rst_n = 1;

        // Reset mid-stream
        issue(2'd0, 5'd0, 5'd1, 5'd2); out_ready = 0; cycle();
        set_idle(); out_ready = 0;
        chk("pre_rst_pending", pending, 32'h0000_0004);
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        issue(2'd1, 5'd3, 5'd4, 5'd9); wb(5'd7, 32'hDEAD_BEEF);
        do_reset();
        set_idle();
        chk("post_rst_stall", {16'b0, stall_cnt}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            issue(2'd0, 5'(2*k), 5'(2*k+1), 5'(k));
            cycle();
            chk("post_rst_rs1_zero", out_rs1, 32'h0);
            chk("post_rst_rs2_zero", out_rs2, 32'h0);
        end
        set_idle(); do_reset(); set_idle();

        // Basic issue
        wb(5'd1, 32'h4086_6666); cycle();
        wb(5'd2, 32'hC000_0000); cycle();
        set_idle(); issue(2'd1, 5'd1, 5'd2, 5'd3); cycle();
        chk("basic_rs1", out_rs1, 32'h4086_6666);
        chk("basic_rs2", out_rs2, 32'hC000_0000);
        chk("basic_rd", {27'b0, out_rd}, 32'd3);
        chk("basic_op", {30'b0, out_op}, 32'd1);
        chk("basic_pend3", {31'b0, pending[3]}, 32'd1);

        // RAW stall then same-cycle writeback forwarding
        set_idle(); issue(2'd0, 5'd3, 5'd0, 5'd4);
        for (int k = 0; k < 4; k++) begin
            #1 chk("raw_ready_low", {31'b0, in_ready}, 32'd0);
            cycle();
        end
        chk("raw_stall_cnt", {16'b0, stall_cnt}, 32'd4);
        wb(5'd3, 32'h3F00_0000); cycle();
        chk("raw_fwd_rs1", out_rs1, 32'h3F00_0000);
        chk("raw_pending", pending, 32'h0000_0010);

        // Backpressure then back-to-back transfer
        set_idle(); out_ready = 0; issue(2'd2, 5'd1, 5'd2, 5'd6);
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_ready_low", {31'b0, in_ready}, 32'd0);
            cycle();
            chk("bp_hold_rd", {27'b0, out_rd}, 32'd4);
            chk("bp_hold_rs1", out_rs1, 32'h3F00_0000);
        end
        out_ready = 1; cycle();
        chk("bp_first_rd", {27'b0, out_rd}, 32'd6);
        issue(2'd3, 5'd1, 5'd2, 5'd7); cycle();
        chk("bp_second_rd", {27'b0, out_rd}, 32'd7);
        chk("bp_second_op", {30'b0, out_op}, 32'd3);
        chk("bp_no_bubble", {31'b0, out_valid}, 32'd1);

        // Simultaneous set/clear of f5
        set_idle(); issue(2'd0, 5'd0, 5'd0, 5'd5); cycle();
        issue(2'd1, 5'd1, 5'd1, 5'd5); wb(5'd5, 32'h1234_5678);
        #1 chk("setclr_ready", {31'b0, in_ready}, 32'd1);
        cycle();
        chk("setclr_pend5", {31'b0, pending[5]}, 32'd1);

        // Random traffic
        set_idle(); do_reset();
        for (int k = 0; k < 2000; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_rs1    = 5'($urandom_range(0, 7));
            in_rs2    = 5'($urandom_range(0, 7));
            in_rd     = 5'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = ($urandom_range(0, 9) < 4);
            wb_data   = $urandom;
            wb_rd     = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < 32; j++) begin
                    if (mpend[j]) begin
                        wb_rd = 5'(j);
                        if ($urandom_range(0, 2) == 0) break;
                    end
                end
            end
            cycle();
        end

        // Stall counter saturation
        set_idle(); do_reset(); set_idle();
        issue(2'd0, 5'd0, 5'd0, 5'd3); cycle();
        issue(2'd0, 5'd3, 5'd0, 5'd4);
        for (int k = 0; k < 70000; k++) cycle();
        chk("sat_stall_cnt", {16'b0, stall_cnt}, 32'h0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
